// File: rtl/ret_addr_stack.sv
// Return-address stack beside the PC: a circular LIFO of link addresses.
// Calls push pc+1, returns pop it back out on top. Every update is qualified
// by en (the PC advance enable), so a stalled cycle never pushes or pops twice.
module ret_addr_stack #(
  parameter int DATAWIDTH = 16,
  parameter int DEPTH     = 8,
  parameter int PTRW      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [DATAWIDTH-1:0] push_addr,
  output logic [DATAWIDTH-1:0] top,
  output logic                 empty,
  output logic                 full,
  output logic [PTRW:0]        count,
  output logic                 ovf,
  output logic                 unf
);

  localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [PTRW-1:0]      sp_q, sp_d;
  logic [PTRW:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 we;
  logic [PTRW-1:0]      waddr;
  logic [PTRW-1:0]      sp_m1;

  // Slot just below the free pointer is the live top; wraps modulo DEPTH.
  assign sp_m1 = sp_q - PTRW'(1);

  // Next-state: flush beats push&pop beats push beats pop; nothing moves without en.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q;
    if (en) begin
      if (flush) begin
        sp_d  = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end else if (push && pop) begin
        if (cnt_q != '0) begin
          // Tail call: replace the top in place; old top goes to the PC this cycle.
          we    = 1'b1;
          waddr = sp_m1;
        end else begin
          we    = 1'b1;
          sp_d  = sp_q + PTRW'(1);
          cnt_d = cnt_q + 1'b1;
          unf_d = 1'b1;
        end
      end else if (push) begin
        // When full the write lands on the oldest slot, losing the deepest return.
        we   = 1'b1;
        sp_d = sp_q + PTRW'(1);
        if (cnt_q == FULL_CNT) ovf_d = 1'b1;
        else                   cnt_d = cnt_q + 1'b1;
      end else if (pop) begin
        if (cnt_q != '0) begin
          sp_d  = sp_m1;
          cnt_d = cnt_q - 1'b1;
        end else begin
          unf_d = 1'b1;
        end
      end
    end
  end

  // Pointer, occupancy and sticky flags; reset discards all entries at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= push_addr;
  end

  assign top   = (cnt_q != '0) ? mem[sp_m1] : '0;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL_CNT);
  assign count = cnt_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed walk through the call/return scenarios,
// then randomized traffic, all checked against a queue-based LIFO model.
module tb_ret_addr_stack;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int PTRW  = 3;

  logic          clk, rst, en, push, pop, flush;
  logic [DW-1:0] push_addr, top;
  logic          empty, full, ovf, unf;
  logic [PTRW:0] count;

  int n_chk, n_err;

  // Reference: queue back is the top; front is the oldest return.
  logic [DW-1:0] mq [$];
  logic          movf, munf;

  ret_addr_stack #(.DATAWIDTH(DW), .DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .flush(flush),
    .push_addr(push_addr), .top(top), .empty(empty), .full(full),
    .count(count), .ovf(ovf), .unf(unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mtop();
    return (mq.size() > 0) ? mq[mq.size()-1] : '0;
  endfunction

  task automatic mclear();
    mq.delete();
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".top"},   32'(top),   32'(mtop()));
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(mq.size() == DEPTH));
    chk({tag, ".ovf"},   32'(ovf),   32'(movf));
    chk({tag, ".unf"},   32'(unf),   32'(munf));
  endtask

  // One cycle: drive after negedge, check top seen in-cycle, clock, check all.
  task automatic step(input logic e, input logic pu, input logic po,
                      input logic fl, input logic [DW-1:0] a, input string tag);
    en = e; push = pu; pop = po; flush = fl; push_addr = a;
    #1;
    chk({tag, ".pre_top"}, 32'(top), 32'(mtop()));
    @(posedge clk);
    if (e) begin
      if (fl) mclear();
      else if (pu && po) begin
        if (mq.size() > 0) mq[mq.size()-1] = a;
        else begin mq.push_back(a); munf = 1'b1; end
      end else if (pu) begin
        if (mq.size() == DEPTH) begin void'(mq.pop_front()); movf = 1'b1; end
        mq.push_back(a);
      end else if (po) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else munf = 1'b1;
      end
    end
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst = 1'b0; en = 0; push = 0; pop = 0; flush = 0; push_addr = '0;
    mclear();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all("reset");
    chk("reset.top0", 32'(top), 32'h0);

    // Basic LIFO.
    step(1, 1, 0, 0, 16'h0011, "push1");
    step(1, 1, 0, 0, 16'h0022, "push2");
    step(1, 1, 0, 0, 16'h0033, "push3");
    chk("lifo.top33", 32'(top), 32'h0033);
    chk("lifo.cnt3",  32'(count), 32'd3);
    step(1, 0, 1, 0, '0, "pop1");
    chk("lifo.top22", 32'(top), 32'h0022);
    step(1, 0, 1, 0, '0, "pop2");
    chk("lifo.top11", 32'(top), 32'h0011);
    step(1, 0, 1, 0, '0, "pop3");
    chk("lifo.empty", 32'(empty), 32'd1);

    // Overflow: nine pushes into eight slots.
    for (int i = 0; i <= 8; i++) step(1, 1, 0, 0, DW'(16'h0100 + i), "ovf_push");
    chk("ovf.full", 32'(full), 32'd1);
    chk("ovf.flag", 32'(ovf),  32'd1);
    chk("ovf.top",  32'(top),  32'h0108);
    for (int i = 0; i < 8; i++) begin
      chk("ovf.pop_val", 32'(top), 32'(16'h0108 - i));
      step(1, 0, 1, 0, '0, "ovf_pop");
    end
    chk("ovf.drained", 32'(empty), 32'd1);

    // Underflow and simultaneous push&pop.
    step(1, 0, 0, 1, '0, "flush0");
    step(1, 0, 1, 0, '0, "unf_pop");
    chk("unf.flag", 32'(unf), 32'd1);
    step(1, 1, 0, 0, 16'h0AAA, "pp_push");
    en = 1; push = 1; pop = 1; flush = 0; push_addr = 16'h0BBB; #1;
    chk("pp.old_top", 32'(top), 32'h0AAA);
    step(1, 1, 1, 0, 16'h0BBB, "pp");
    chk("pp.new_top", 32'(top), 32'h0BBB);
    chk("pp.cnt1",    32'(count), 32'd1);
    step(1, 0, 0, 1, '0, "flush1");
    step(1, 1, 1, 0, 16'h0CCC, "pp_empty");
    chk("ppe.top", 32'(top), 32'h0CCC);
    chk("ppe.unf", 32'(unf), 32'd1);

    // Enable gating and flush priority.
    step(1, 0, 0, 1, '0, "flush2");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 16'hDEAD, "gated");
    chk("gate.cnt0", 32'(count), 32'd0);
    step(1, 1, 0, 0, 16'h1234, "en_push");
    step(1, 1, 0, 1, 16'h5555, "flush_push");
    chk("flush.top0", 32'(top), 32'h0);

    // Async reset between edges with five entries.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, DW'(16'h0200 + i), "pre_rst");
    #2 rst = 1'b0;
    #1;
    mclear();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(empty), 32'd1);
    chk("arst.top",   32'(top),   32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 0, 0, 16'h7777, "post_rst");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic e, pu, po, fl;
      e  = ($urandom_range(0, 3) != 0);
      pu = ($urandom_range(0, 1) != 0);
      po = ($urandom_range(0, 9) < 4);
      fl = ($urandom_range(0, 39) == 0);
      step(e, pu, po, fl, DW'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
